// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// RV32I pipeline MEM stage. Holds the byte-addressed data RAM (single-port,
// read-first, synchronous read) serving LB/LH/LW/LBU/LHU/SB/SH/SW, and the
// MEM/WB pipeline register feeding WB.
//
// Parameters
//   DEPTH_WORDS   data RAM depth in 32-bit words (word index taken from
//                 alu_result_i[log2(DEPTH_WORDS)+1:2]; higher bits wrap)
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-low reset
//   stall_i       hold MEM/WB register and RAM read data, suppress write
//   flush_i       bubble into MEM/WB (wins over stall), suppress write
//   regwrite_i / rd_addr_i / memtoreg_i / pc_address_i / alu_result_i
//                 EX-stage control and data carried into MEM/WB
//   store_data_i  rs2 value for stores
//   memread_i / memwrite_i / funct3_i   load/store type and access size
//   ex_valid_i    EX slot holds a valid instruction
//   regwrite_o / rd_addr_o / memtoreg_o / pc_address_o / alu_result_o /
//   mem_valid_o   registered MEM/WB fields
//   mem_data_o    load data, aligned and sign/zero extended (0 for non-loads)
//
// Optional feature (macro MEMSTAGE_MISALIGN_CHECK_EN)
//   Adds registered output misalign_o flagging halfword accesses with an odd
//   address and word accesses not on a 4-byte boundary. Such stores are
//   dropped and such loads return 0.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        regwrite_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [1:0]  memtoreg_i,
    input  logic [31:0] pc_address_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    input  logic        ex_valid_i,
    output logic        regwrite_o,
    output logic [4:0]  rd_addr_o,
    output logic [1:0]  memtoreg_o,
    output logic [31:0] pc_address_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] mem_data_o,
    output logic        mem_valid_o
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Extract and extend the addressed byte/half/word from a RAM word.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_align = {{24{b[7]}}, b};
            F3_BU:   load_align = {24'd0, b};
            F3_H:    load_align = {{16{h[15]}}, h};
            F3_HU:   load_align = {16'd0, h};
            F3_W:    load_align = word;
            default: load_align = 32'd0;
        endcase
    endfunction

    logic [31:0]   ram_r [DEPTH_WORDS];
    logic [31:0]   dout_r;

    logic [AW-1:0] idx_s;
    logic [1:0]    off_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic          we_s;
    logic          misaligned_s;
    logic [31:0]   mem_data_s;

    logic          regwrite_r;
    logic [4:0]    rd_addr_r;
    logic [1:0]    memtoreg_r;
    logic [31:0]   pc_address_r;
    logic [31:0]   alu_result_r;
    logic          mem_valid_r;
    logic          memread_r;
    logic [2:0]    funct3_r;
    logic [1:0]    off_r;
    logic          misalign_r;

    // Address bits above the RAM index are intentionally dropped (wrap).
    logic          unused_addr_s;
    assign unused_addr_s = &{1'b0, alu_result_i[31:AW+2]};

    assign idx_s = alu_result_i[AW+1:2];
    assign off_s = alu_result_i[1:0];

    // Detect accesses whose size is not naturally aligned.
    always_comb begin
        misaligned_s = 1'b0;
        if (memread_i || memwrite_i) begin
            case (funct3_i)
                F3_H, F3_HU: misaligned_s = off_s[0];
                F3_W:        misaligned_s = (off_s != 2'b00);
                default:     misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Byte-lane enables and lane-replicated store data; SH/SW ignore the
    // low address bits below their natural alignment.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = store_data_i;
        case (funct3_i)
            F3_B: begin
                be_s    = 4'b0001 << off_s;
                wdata_s = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                be_s    = off_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{store_data_i[15:0]}};
            end
            F3_W: begin
                be_s    = 4'b1111;
                wdata_s = store_data_i;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = store_data_i;
            end
        endcase
    end

    // Store commits only for a live, unstalled, unflushed instruction.
    always_comb begin
        we_s = memwrite_i & ex_valid_i & ~stall_i & ~flush_i;
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
        if (misaligned_s) begin
            we_s = 1'b0;
        end else begin
            we_s = memwrite_i & ex_valid_i & ~stall_i & ~flush_i;
        end
`endif
    end

    // Data RAM: read-first registered read port plus byte-lane writes.
    always_ff @(posedge clk_i) begin
        if (!stall_i) begin
            dout_r <= ram_r[idx_s];
        end
        for (int i = 0; i < 4; i++) begin
            if (we_s && be_s[i]) begin
                ram_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
        end
    end

    // MEM/WB pipeline register: flush inserts a bubble, stall holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            regwrite_r   <= 1'b0;
            rd_addr_r    <= 5'd0;
            memtoreg_r   <= 2'b00;
            pc_address_r <= 32'd0;
            alu_result_r <= 32'd0;
            mem_valid_r  <= 1'b0;
            memread_r    <= 1'b0;
            funct3_r     <= 3'b000;
            off_r        <= 2'b00;
            misalign_r   <= 1'b0;
        end else if (flush_i) begin
            regwrite_r   <= 1'b0;
            rd_addr_r    <= rd_addr_i;
            memtoreg_r   <= memtoreg_i;
            pc_address_r <= pc_address_i;
            alu_result_r <= alu_result_i;
            mem_valid_r  <= 1'b0;
            memread_r    <= 1'b0;
            funct3_r     <= funct3_i;
            off_r        <= off_s;
            misalign_r   <= 1'b0;
        end else if (!stall_i) begin
            regwrite_r   <= regwrite_i;
            rd_addr_r    <= rd_addr_i;
            memtoreg_r   <= memtoreg_i;
            pc_address_r <= pc_address_i;
            alu_result_r <= alu_result_i;
            mem_valid_r  <= ex_valid_i;
            memread_r    <= memread_i;
            funct3_r     <= funct3_i;
            off_r        <= off_s;
            misalign_r   <= misaligned_s;
        end
    end

    // Load data formatting from the held RAM word and registered access info.
    always_comb begin
        if (memread_r) begin
            mem_data_s = load_align(dout_r, funct3_r, off_r);
        end else begin
            mem_data_s = 32'd0;
        end
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
        if (misalign_r) begin
            mem_data_s = 32'd0;
        end else begin
            mem_data_s = mem_data_s;
        end
`endif
    end

    assign regwrite_o   = regwrite_r;
    assign rd_addr_o    = rd_addr_r;
    assign memtoreg_o   = memtoreg_r;
    assign pc_address_o = pc_address_r;
    assign alu_result_o = alu_result_r;
    assign mem_valid_o  = mem_valid_r;
    assign mem_data_o   = mem_data_s;

`ifdef MEMSTAGE_MISALIGN_CHECK_EN
    assign misalign_o = misalign_r;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = &{1'b0, misalign_r, misaligned_s};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. A byte-array memory model plus a set of
// expected MEM/WB fields is advanced once per clock from the applied inputs;
// every cycle all outputs are compared against it, and literal values pin
// the key results.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, regwrite, memread, memwrite, ex_valid;
    logic [4:0]  rd_addr;
    logic [1:0]  memtoreg;
    logic [31:0] pc_address, alu_result, store_data;
    logic [2:0]  funct3;

    logic        regwrite_o, mem_valid_o;
    logic [4:0]  rd_addr_o;
    logic [1:0]  memtoreg_o;
    logic [31:0] pc_address_o, alu_result_o, mem_data_o;
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    mem_stage #(.DEPTH_WORDS(1024)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .regwrite_i   (regwrite),
        .rd_addr_i    (rd_addr),
        .memtoreg_i   (memtoreg),
        .pc_address_i (pc_address),
        .alu_result_i (alu_result),
        .store_data_i (store_data),
        .memread_i    (memread),
        .memwrite_i   (memwrite),
        .funct3_i     (funct3),
        .ex_valid_i   (ex_valid),
        .regwrite_o   (regwrite_o),
        .rd_addr_o    (rd_addr_o),
        .memtoreg_o   (memtoreg_o),
        .pc_address_o (pc_address_o),
        .alu_result_o (alu_result_o),
        .mem_data_o   (mem_data_o),
        .mem_valid_o  (mem_valid_o)
`ifdef MEMSTAGE_MISALIGN_CHECK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_mem   [4096];
    bit          m_known [4096];
    logic        e_regwrite, e_valid;
    logic [4:0]  e_rd;
    logic [1:0]  e_memtoreg;
    logic [31:0] e_pc, e_alu, e_data;
    bit          e_data_known;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // What a load of the given type at the given address must return.
    task automatic model_load(input logic [2:0] f3, input logic [31:0] a,
                              output logic [31:0] val, output bit known);
        int base, off, hb;
        logic [15:0] h;
        base  = int'(a[11:2]) * 4;
        off   = int'(a[1:0]);
        hb    = base + (a[1] ? 2 : 0);
        h     = {m_mem[hb+1], m_mem[hb]};
        known = 1'b1;
        case (f3)
            3'b000: begin val = {{24{m_mem[base+off][7]}}, m_mem[base+off]}; known = m_known[base+off]; end
            3'b100: begin val = {24'd0, m_mem[base+off]}; known = m_known[base+off]; end
            3'b001: begin val = {{16{h[15]}}, h}; known = m_known[hb] && m_known[hb+1]; end
            3'b101: begin val = {16'd0, h}; known = m_known[hb] && m_known[hb+1]; end
            3'b010: begin
                val   = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
                known = m_known[base] && m_known[base+1] && m_known[base+2] && m_known[base+3];
            end
            default: val = 32'd0;
        endcase
    endtask

    task automatic put_byte(input int i, input logic [7:0] b);
        m_mem[i]   = b;
        m_known[i] = 1'b1;
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        logic [31:0] lv;
        bit          lk;
        int base, hb;
        if (flush) begin
            e_regwrite = 1'b0; e_valid = 1'b0;
            e_rd = rd_addr; e_memtoreg = memtoreg; e_pc = pc_address; e_alu = alu_result;
            e_data = 32'd0; e_data_known = 1'b1;
        end else if (!stall) begin
            e_regwrite = regwrite; e_valid = ex_valid;
            e_rd = rd_addr; e_memtoreg = memtoreg; e_pc = pc_address; e_alu = alu_result;
            if (memread) begin
                model_load(funct3, alu_result, lv, lk);
                e_data = lv; e_data_known = lk;
            end else begin
                e_data = 32'd0; e_data_known = 1'b1;
            end
        end
        // store happens after the read: old contents were returned above
        if (memwrite && ex_valid && !stall && !flush) begin
            base = int'(alu_result[11:2]) * 4;
            hb   = base + (alu_result[1] ? 2 : 0);
            case (funct3)
                3'b000: put_byte(base + int'(alu_result[1:0]), store_data[7:0]);
                3'b001: begin put_byte(hb, store_data[7:0]); put_byte(hb+1, store_data[15:8]); end
                3'b010: for (int i = 0; i < 4; i++) put_byte(base + i, store_data[8*i +: 8]);
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("regwrite_o",   {31'd0, regwrite_o},  {31'd0, e_regwrite});
        chk("rd_addr_o",    {27'd0, rd_addr_o},   {27'd0, e_rd});
        chk("memtoreg_o",   {30'd0, memtoreg_o},  {30'd0, e_memtoreg});
        chk("pc_address_o", pc_address_o,         e_pc);
        chk("alu_result_o", alu_result_o,         e_alu);
        chk("mem_valid_o",  {31'd0, mem_valid_o}, {31'd0, e_valid});
        if (e_data_known) chk("mem_data_o", mem_data_o, e_data);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drv(input logic rw, input logic [4:0] rd, input logic [1:0] mt,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                       input logic mr, input logic mw, input logic [2:0] f3,
                       input logic v, input logic st, input logic fl);
        regwrite = rw; rd_addr = rd; memtoreg = mt; pc_address = pc;
        alu_result = alu; store_data = sd; memread = mr; memwrite = mw;
        funct3 = f3; ex_valid = v; stall = st; flush = fl;
        cycle();
    endtask

    task automatic st_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        drv(1'b0, 5'd0, 2'b00, 32'h0000_0100, a, d, 1'b0, 1'b1, f3, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ld_op(input logic [2:0] f3, input logic [31:0] a);
        drv(1'b1, 5'd7, 2'b01, 32'h0000_0200, a, 32'd0, 1'b1, 1'b0, f3, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin m_mem[i] = 8'h00; m_known[i] = 1'b0; end
        e_regwrite = 1'b0; e_valid = 1'b0; e_rd = 5'd0; e_memtoreg = 2'b00;
        e_pc = 32'd0; e_alu = 32'd0; e_data = 32'd0; e_data_known = 1'b1;

        rst = 1'b0; stall = 1'b0; flush = 1'b0; regwrite = 1'b1; memread = 1'b1;
        memwrite = 1'b0; ex_valid = 1'b1; rd_addr = 5'd3; memtoreg = 2'b01;
        pc_address = 32'h44; alu_result = 32'h8; store_data = 32'd0; funct3 = 3'b010;
        #20;
        chk("rst regwrite_o",   {31'd0, regwrite_o},  32'd0);
        chk("rst rd_addr_o",    {27'd0, rd_addr_o},   32'd0);
        chk("rst memtoreg_o",   {30'd0, memtoreg_o},  32'd0);
        chk("rst pc_address_o", pc_address_o,         32'd0);
        chk("rst alu_result_o", alu_result_o,         32'd0);
        chk("rst mem_data_o",   mem_data_o,           32'd0);
        chk("rst mem_valid_o",  {31'd0, mem_valid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: basic word stores and load
        st_op(3'b010, 32'h0, 32'hDDCC_BBAA);
        st_op(3'b010, 32'h4, 32'h4433_2211);
        ld_op(3'b010, 32'h0);
        chk("lw0 literal", mem_data_o, 32'hDDCC_BBAA);

        // 2: sub-word stores
        st_op(3'b000, 32'h3, 32'h1122_3344);
        ld_op(3'b010, 32'h0);
        chk("sb literal", mem_data_o, 32'h44CC_BBAA);
        st_op(3'b001, 32'h0, 32'hAABB_CCDD);
        st_op(3'b010, 32'h4, 32'h1234_5678);
        ld_op(3'b010, 32'h0);
        chk("sh literal", mem_data_o, 32'h44CC_CCDD);

        // 3: load sizes and extension
        ld_op(3'b000, 32'h3);  chk("lb3 literal",  mem_data_o, 32'h0000_0044);
        ld_op(3'b001, 32'h0);  chk("lh0 literal",  mem_data_o, 32'hFFFF_CCDD);
        ld_op(3'b010, 32'h4);  chk("lw4 literal",  mem_data_o, 32'h1234_5678);
        ld_op(3'b100, 32'h2);  chk("lbu2 literal", mem_data_o, 32'h0000_00CC);
        ld_op(3'b101, 32'h2);  chk("lhu2 literal", mem_data_o, 32'h0000_44CC);
        ld_op(3'b000, 32'h2);  chk("lb2 literal",  mem_data_o, 32'hFFFF_FFCC);
        ld_op(3'b111, 32'h0);  chk("ld f3=111",    mem_data_o, 32'h0000_0000);

        // 4: plain ALU op passes through
        drv(1'b1, 5'd10, 2'b00, 32'h1000, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("alu rd literal",  {27'd0, rd_addr_o}, 32'd10);
        chk("alu pc literal",  pc_address_o, 32'h1000);
        chk("alu res literal", alu_result_o, 32'hDEAD_BEEF);
        chk("alu data zero",   mem_data_o,   32'd0);

        // 5: stall holds outputs and blocks a pending store
        drv(1'b1, 5'd1, 2'b10, 32'h2000, 32'h10, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 5'd2, 2'b10, 32'h2004, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
        chk("stall pc held",  pc_address_o, 32'h2000);
        chk("stall rd held",  {27'd0, rd_addr_o}, 32'd1);
        chk("stall wr held",  {31'd0, regwrite_o}, 32'd1);
        drv(1'b1, 5'd3, 2'b10, 32'h2008, 32'h14, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        ld_op(3'b010, 32'h0);
        chk("stall no write", mem_data_o, 32'h44CC_CCDD);

        // 6: flush bubbles and blocks the store; reserved funct3 store ignored
        drv(1'b1, 5'd4, 2'b00, 32'h3000, 32'h4, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1);
        chk("flush regwrite", {31'd0, regwrite_o},  32'd0);
        chk("flush valid",    {31'd0, mem_valid_o}, 32'd0);
        st_op(3'b111, 32'h4, 32'h0);
        ld_op(3'b010, 32'h4);
        chk("flush/f3 no write", mem_data_o, 32'h1234_5678);

        // flush while a load is in flight forces zero data
        drv(1'b1, 5'd5, 2'b01, 32'h3004, 32'h4, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1);
        chk("flush load data", mem_data_o, 32'd0);

        // invalid slot: no write, valid output low, regwrite still passed
        drv(1'b1, 5'd6, 2'b00, 32'h3008, 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("invalid regwrite", {31'd0, regwrite_o}, 32'd1);
        ld_op(3'b010, 32'h4);
        chk("invalid no write", mem_data_o, 32'h1234_5678);

        // address wrap modulo depth, and misaligned SW/SH ignore low bits
        st_op(3'b010, 32'h0000_1008, 32'hCAFE_F00D);
        ld_op(3'b010, 32'h8);
        chk("wrap literal", mem_data_o, 32'hCAFE_F00D);
`ifndef MEMSTAGE_MISALIGN_CHECK_EN
        st_op(3'b001, 32'h0000_000B, 32'h0000_1357);
        ld_op(3'b010, 32'h8);
        chk("sh misaligned", mem_data_o, 32'h1357_F00D);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
